// File: rtl/i_arbiter_4_2_if.sv
// Request/grant bundle for the i_arbiter_4_2 round-robin arbiter.
//   req_n    : per-requester request, active low (0 = requesting)
//   gnt_n    : registered one-cold grant, active low
//   b        : encoded index of the current/last granted requester
//   valid    : high while a grant is active
//   busy_cnt : current hold count, for observation
// The master modport belongs to the requester side; the slave modport to the arbiter.
interface i_arbiter_4_2_if #(
  parameter int unsigned CNT_W = 4
);
  logic [3:0]       req_n;
  logic [3:0]       gnt_n;
  logic [1:0]       b;
  logic             valid;
  logic [CNT_W-1:0] busy_cnt;

  modport master (
    output req_n,
    input  gnt_n,
    input  b,
    input  valid,
    input  busy_cnt
  );

  modport slave (
    input  req_n,
    output gnt_n,
    output b,
    output valid,
    output busy_cnt
  );
endinterface

// File: rtl/i_arbiter_4_2.sv
// Four-way round-robin arbiter with active-low (one-cold) requests and grants.
// The grant index b is emitted in the same 2-bit encoded form produced by the
// i_encoder_4_2 family. A hold timer forces the owner off the resource after
// MAX_HOLD grant cycles when another requester is waiting (MAX_HOLD = 0 disables).
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : slave side of i_arbiter_4_2_if (req_n in; gnt_n, b, valid, busy_cnt out)
// All outputs are registered; nothing in req_n reaches an output combinationally.
module i_arbiter_4_2 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic            clk,
  input  logic            reset,
  i_arbiter_4_2_if.slave  bus
);

  // Last busy_cnt value of a full hold period; only meaningful when MAX_HOLD != 0.
  localparam logic [CNT_W-1:0] HoldLast = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StRelease
  } state_e;

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [3:0]       gnt_n_q;
  logic [1:0]       b_q;
  logic             valid_q;
  logic [CNT_W-1:0] busy_cnt_q;

  logic       found;
  logic [1:0] win;
  logic [1:0] idx;
  logic       owner_released;
  logic       others_pending;
  logic       preempt;

  // Round-robin pick: first requesting index at or above ptr, wrapping 3 -> 0.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && !bus.req_n[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    owner_released = bus.req_n[b_q];
    others_pending = |(~bus.req_n & ~(4'b0001 << b_q));
    preempt        = (MAX_HOLD != 0) && (busy_cnt_q == HoldLast) && others_pending;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= 2'd0;
      gnt_n_q    <= 4'b1111;
      b_q        <= 2'd0;
      valid_q    <= 1'b0;
      busy_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            state_q    <= StGrant;
            gnt_n_q    <= ~(4'b0001 << win);
            b_q        <= win;
            valid_q    <= 1'b1;
            busy_cnt_q <= '0;
          end
        end
        StGrant: begin
          if (busy_cnt_q != CntMax) begin
            busy_cnt_q <= busy_cnt_q + CNT_W'(1);
          end
          // Owner release takes priority over preemption; both end in RELEASE.
          if (owner_released || preempt) begin
            state_q    <= StRelease;
            gnt_n_q    <= 4'b1111;
            valid_q    <= 1'b0;
            busy_cnt_q <= '0;
          end
        end
        StRelease: begin
          // b keeps the last owner so the search resumes just past it.
          ptr_q   <= b_q + 2'd1;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.gnt_n    = gnt_n_q;
  assign bus.b        = b_q;
  assign bus.valid    = valid_q;
  assign bus.busy_cnt = busy_cnt_q;

endmodule

// File: doc/i_arbiter_4_2.md
Name: i_arbiter_4_2

Overview:
- Round-robin arbiter that shares one downstream resource between four requesters.
- Requests arrive on active-low lines, the same one-cold convention used by the i_encoder_4_2 family.
- Outputs are a registered one-cold grant vector and a 2-bit encoded grant index, so downstream logic consumes the same encoded form it gets from the combinational encoder.
- A hold timer preempts a requester that keeps the resource while others wait.

Parameters:
- MAX_HOLD, 8: max consecutive GRANT cycles before forced release when another request is pending. 0 disables preemption.
- CNT_W, 4: width of hold counter. Must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_n  input  4  request per requester, active low (0 = requesting).
- gnt_n  output  4  registered grant, active low, at most one bit low.
- b  output  2  encoded index of current/last granted requester.
- valid  output  1  high while a grant is active.
- busy_cnt  output  CNT_W  current hold count, for debug/observation.

Behaviour:
- Reset (asynchronous, any time including mid-grant):
  - state=IDLE, ptr=0, gnt_n=4'b1111, b=2'b00, valid=0, busy_cnt=0.
  - Any active grant is dropped immediately; no RELEASE cycle occurs.
- All outputs are registered; there is no combinational path from req_n to outputs.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req_n==4'b1111, stay in IDLE with outputs idle.
  - Otherwise select the first low bit searching upward from ptr, wrapping 3->0.
  - At the next edge: state=GRANT, gnt_n has only bit w low, b=w, valid=1, busy_cnt=0.
  - Latency: request sampled at edge k, grant visible after edge k.
- GRANT:
  - busy_cnt increments each cycle and saturates at 2**CNT_W-1.
  - If req_n[b]==1 (owner released), next state is RELEASE. This takes priority over preemption.
  - Else if MAX_HOLD!=0 and busy_cnt==MAX_HOLD-1 and any other req_n bit is low, next state is RELEASE (preempted).
  - Else stay in GRANT. A lone requester holds indefinitely.
- RELEASE (exactly one cycle):
  - gnt_n=4'b1111, valid=0, busy_cnt=0.
  - b retains the last granted index.
  - ptr=(b+1) mod 4 (2-bit wrap).
  - Next state is IDLE unconditionally.
  - Minimum gap between consecutive grants: 2 cycles with valid=0 (RELEASE + IDLE).
- Multiple simultaneous requests are resolved only by ptr order; index value carries no fixed priority.
- A request that drops in the same cycle it is sampled in IDLE is still granted. The grant then releases on the following GRANT cycle, since req_n[b]==1.
- Invariants:
  - gnt_n is never more than one-cold.
  - valid==1 exactly when gnt_n!=4'b1111.
  - When valid==1, gnt_n==~(4'b0001<<b).

Test Plan:
- Reset, then req_n=4'b1110 held 3 cycles, then 4'b1111:
  - gnt_n=4'b1110, b=0, valid=1 one cycle after the request.
  - Grant held while the request stays low.
  - One RELEASE cycle with valid=0, then IDLE.
- All requesting, req_n=4'b0000 held, MAX_HOLD=8:
  - Grants cycle b=0,1,2,3,0…
  - Each grant lasts exactly 8 cycles, separated by 2-cycle gaps.
- Lone requester req_n=4'b0111 held 20 cycles:
  - b=3 held for all 20 cycles, no preemption.
  - busy_cnt saturates at 15.
- After a grant to 2 is released, apply req_n=4'b1010 (requesters 0 and 2):
  - Next grant is b=0, because ptr=3 wraps to 0.
- Apply reset mid-grant while req_n=4'b1101, b=1:
  - Outputs go to gnt_n=4'b1111, valid=0, b=0 immediately, without waiting for clk.
  - After reset deasserts, b=1 is re-granted one cycle later.
- Owner releases in the same cycle busy_cnt==MAX_HOLD-1 with others pending:
  - Exactly one RELEASE cycle occurs.
  - ptr advances to b+1.
